// File: rtl/hud_pkg.sv
// Shared types and constants for the HUD digit renderer: digit type, row and
// blink-state enums, per-row digit counts and BCD saturation.
package hud_pkg;

    typedef logic [3:0] bcd_t;

    typedef enum logic [1:0] {
        ROW_SCORE,
        ROW_SPEED,
        ROW_FUEL
    } row_e;

    typedef enum logic {
        STEADY,
        BLINK
    } blink_state_e;

    localparam int SCORE_DIGITS = 4;
    localparam int SPEED_DIGITS = 3;
    localparam int FUEL_DIGITS  = 2;

    // Inputs are compared at their full width so a 5-bit 18 clamps to 9.
    function automatic bcd_t sat_bcd(input logic [4:0] d);
        return (d > 5'd9) ? 4'd9 : d[3:0];
    endfunction

endpackage

// File: rtl/hud_blink_timer.sv
// Low-fuel blink timer: STEADY/BLINK state, frame counter and display phase,
// advanced once per startOfFrame. state_dbg exposes the FSM state.
module hud_blink_timer
    import hud_pkg::*;
#(
    parameter int BLINK_FRAMES = 15
) (
    input  logic         clk,
    input  logic         resetN,
    input  logic         startOfFrame,
    input  logic         fuelLow,
    output logic         phase,
    output blink_state_e state_dbg
);

    localparam int CW = $clog2(BLINK_FRAMES + 1);

    blink_state_e   state_q;
    logic [CW-1:0]  count_q;
    logic           phase_q;

    // fuelLow lags the snapshot by one clock, so the frame that captured a low
    // value is still shown steadily; blinking starts at the following frame.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= STEADY;
            count_q <= '0;
            phase_q <= 1'b1;
        end else if (startOfFrame) begin
            case (state_q)
                STEADY: begin
                    count_q <= '0;
                    phase_q <= 1'b1;
                    if (fuelLow)
                        state_q <= BLINK;
                end
                BLINK: begin
                    if (!fuelLow) begin
                        state_q <= STEADY;
                        count_q <= '0;
                        phase_q <= 1'b1;
                    end else if (count_q == CW'(BLINK_FRAMES - 1)) begin
                        count_q <= '0;
                        phase_q <= ~phase_q;
                    end else begin
                        count_q <= count_q + CW'(1);
                    end
                end
                default: state_q <= STEADY;
            endcase
        end
    end

    assign phase     = phase_q;
    assign state_dbg = state_q;

endmodule

// File: rtl/hud_digit_display.sv
// HUD digit renderer: per-frame snapshot of score/speed/fuel BCD buses and a
// two-stage pixel pipeline. Define HUD_LEADING_ZERO_BLANK_EN for leading-zero blanking.
module hud_digit_display
    import hud_pkg::*;
#(
    parameter int HUD_X           = 520,
    parameter int HUD_Y           = 16,
    parameter int DIGIT_W         = 16,
    parameter int DIGIT_H         = 32,
    parameter int ROW_GAP         = 8,
    parameter int LOW_FUEL_THRESH = 20,
    parameter int BLINK_FRAMES    = 15
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic [10:0] pixelX,
    input  logic [10:0] pixelY,
    input  logic [3:0]  scoreMMsb,
    input  logic [3:0]  scoreMLsb,
    input  logic [3:0]  scoreLMsb,
    input  logic [4:0]  scoreLLsb,
    input  logic [3:0]  speedMsb,
    input  logic [3:0]  speedMidb,
    input  logic [3:0]  speedLsb,
    input  logic [3:0]  fuelMsb,
    input  logic [3:0]  fuelLsb,
    output logic        drawingRequest,
    output logic [3:0]  digitCode,
    output logic [4:0]  offsetX,
    output logic [5:0]  offsetY,
    output logic        fuelLow
);

`ifdef HUD_LEADING_ZERO_BLANK_EN
    localparam bit BLANK_EN = 1'b1;
`else
    localparam bit BLANK_EN = 1'b0;
`endif

    localparam int          LOG2_W    = $clog2(DIGIT_W);
    localparam int          ROW_PITCH = DIGIT_H + ROW_GAP;
    localparam logic [10:0] HUD_X11   = 11'(HUD_X);
    localparam logic [10:0] ROW_TOP0  = 11'(HUD_Y);
    localparam logic [10:0] ROW_TOP1  = 11'(HUD_Y + ROW_PITCH);
    localparam logic [10:0] ROW_TOP2  = 11'(HUD_Y + 2 * ROW_PITCH);
    localparam logic [10:0] H11       = 11'(DIGIT_H);
    localparam logic [10:0] W_MASK    = 11'(DIGIT_W - 1);
    localparam logic [10:0] H_MASK    = 11'(DIGIT_H - 1);

    // Shadow registers: index 0 is the rightmost digit of each field.
    bcd_t [SCORE_DIGITS-1:0] score_q, score_d;
    bcd_t [SPEED_DIGITS-1:0] speed_q, speed_d;
    bcd_t [FUEL_DIGITS-1:0]  fuel_q,  fuel_d;
    logic                    fuel_low_q, fuel_low_d;

    logic       s1_hit_q, s1_hit_d;
    row_e       s1_row_q, s1_row_d;
    logic [1:0] s1_col_q, s1_col_d;
    logic [4:0] s1_offx_q, s1_offx_d;
    logic [5:0] s1_offy_q, s1_offy_d;

    logic       draw_q, draw_d;
    bcd_t       code_q, code_d;
    logic [4:0] offx_q, offx_d;
    logic [5:0] offy_q, offy_d;

    logic         blink_phase;
    blink_state_e blink_state;
    logic         blink_dark;

    logic [10:0] dx, dy0, dy1, dy2, dy_sel, col_full;
    logic        x_ok;
    bcd_t        digit;
    logic        lead_zero;

    always_comb begin
        score_d = score_q;
        speed_d = speed_q;
        fuel_d  = fuel_q;
        if (startOfFrame) begin
            score_d = {sat_bcd({1'b0, scoreMMsb}), sat_bcd({1'b0, scoreMLsb}),
                       sat_bcd({1'b0, scoreLMsb}), sat_bcd(scoreLLsb)};
            speed_d = {sat_bcd({1'b0, speedMsb}), sat_bcd({1'b0, speedMidb}),
                       sat_bcd({1'b0, speedLsb})};
            fuel_d  = {sat_bcd({1'b0, fuelMsb}), sat_bcd({1'b0, fuelLsb})};
        end
        fuel_low_d = (({4'd0, fuel_q[1]} * 8'd10) + {4'd0, fuel_q[0]}) < 8'(LOW_FUEL_THRESH);
    end

    // Stage 1: the >= guards stop wrapped differences left of/above the HUD aliasing into a cell.
    always_comb begin
        dx       = pixelX - HUD_X11;
        x_ok     = (pixelX >= HUD_X11);
        col_full = dx >> LOG2_W;
        dy0      = pixelY - ROW_TOP0;
        dy1      = pixelY - ROW_TOP1;
        dy2      = pixelY - ROW_TOP2;
        dy_sel   = dy0;
        s1_hit_d = 1'b0;
        s1_row_d = ROW_SCORE;
        s1_col_d = '0;
        s1_offx_d = '0;
        s1_offy_d = '0;
        if (x_ok && pixelY >= ROW_TOP0 && dy0 < H11 && col_full < 11'(SCORE_DIGITS)) begin
            s1_hit_d = 1'b1;
        end else if (x_ok && pixelY >= ROW_TOP1 && dy1 < H11 && col_full < 11'(SPEED_DIGITS)) begin
            s1_hit_d = 1'b1;
            s1_row_d = ROW_SPEED;
            dy_sel   = dy1;
        end else if (x_ok && pixelY >= ROW_TOP2 && dy2 < H11 && col_full < 11'(FUEL_DIGITS)) begin
            s1_hit_d = 1'b1;
            s1_row_d = ROW_FUEL;
            dy_sel   = dy2;
        end
        if (s1_hit_d) begin
            s1_col_d  = col_full[1:0];
            s1_offx_d = 5'(dx & W_MASK);
            s1_offy_d = 6'(dy_sel & H_MASK);
        end
    end

    assign blink_dark = (blink_state == BLINK) && !blink_phase;

    // Stage 2: a digit is a leading zero when it and every digit to its left are zero.
    always_comb begin
        digit     = '0;
        lead_zero = 1'b0;
        case (s1_row_q)
            ROW_SCORE: begin
                case (s1_col_q)
                    2'd0: begin digit = score_q[3]; lead_zero = (score_q[3] == '0);   end
                    2'd1: begin digit = score_q[2]; lead_zero = (score_q[3:2] == '0); end
                    2'd2: begin digit = score_q[1]; lead_zero = (score_q[3:1] == '0); end
                    default: digit = score_q[0];
                endcase
            end
            ROW_SPEED: begin
                case (s1_col_q)
                    2'd0: begin digit = speed_q[2]; lead_zero = (speed_q[2] == '0);   end
                    2'd1: begin digit = speed_q[1]; lead_zero = (speed_q[2:1] == '0); end
                    default: digit = speed_q[0];
                endcase
            end
            ROW_FUEL: digit = s1_col_q[0] ? fuel_q[0] : fuel_q[1];
            default: ;
        endcase
        draw_d = s1_hit_q && !(BLANK_EN && lead_zero) && !((s1_row_q == ROW_FUEL) && blink_dark);
        code_d = s1_hit_q ? digit : '0;
        offx_d = s1_offx_q;
        offy_d = s1_offy_q;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            score_q    <= '0;
            speed_q    <= '0;
            fuel_q     <= {4'd9, 4'd9};
            fuel_low_q <= 1'b0;
            s1_hit_q   <= 1'b0;
            s1_row_q   <= ROW_SCORE;
            s1_col_q   <= '0;
            s1_offx_q  <= '0;
            s1_offy_q  <= '0;
            draw_q     <= 1'b0;
            code_q     <= '0;
            offx_q     <= '0;
            offy_q     <= '0;
        end else begin
            score_q    <= score_d;
            speed_q    <= speed_d;
            fuel_q     <= fuel_d;
            fuel_low_q <= fuel_low_d;
            s1_hit_q   <= s1_hit_d;
            s1_row_q   <= s1_row_d;
            s1_col_q   <= s1_col_d;
            s1_offx_q  <= s1_offx_d;
            s1_offy_q  <= s1_offy_d;
            draw_q     <= draw_d;
            code_q     <= code_d;
            offx_q     <= offx_d;
            offy_q     <= offy_d;
        end
    end

    hud_blink_timer #(
        .BLINK_FRAMES (BLINK_FRAMES)
    ) u_blink (
        .clk          (clk),
        .resetN       (resetN),
        .startOfFrame (startOfFrame),
        .fuelLow      (fuel_low_q),
        .phase        (blink_phase),
        .state_dbg    (blink_state)
    );

    assign drawingRequest = draw_q;
    assign digitCode      = code_q;
    assign offsetX        = offx_q;
    assign offsetY        = offy_q;
    assign fuelLow        = fuel_low_q;

endmodule
